// File: rtl/level_fifo.sv
// Single-clock show-ahead FIFO with occupancy level and almost-full/almost-empty flags.
// Optional overflow/drop counter is built when LEVEL_FIFO_DROP_CNT_EN is defined.
module level_fifo #(
    parameter int ASIZE     = 4,
    parameter int DSIZE     = 32,
    parameter int AF_THRESH = 2**ASIZE - 2,
    parameter int AE_THRESH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_n,
    input  logic [DSIZE-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [DSIZE-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [ASIZE:0]   level,
    output logic             almost_full,
    output logic             almost_empty
`ifdef LEVEL_FIFO_DROP_CNT_EN
    ,
    output logic             overflow,
    output logic [7:0]       drop_cnt
`endif
);

    localparam int             DEPTH   = 2**ASIZE;
    localparam logic [ASIZE:0] AF_LVL  = (ASIZE+1)'(AF_THRESH);
    localparam logic [ASIZE:0] AE_LVL  = (ASIZE+1)'(AE_THRESH);
    localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

    // Handshake: a beat transfers on a rising edge where valid && ready are both high;
    // ready/valid here come only from registered pointers, so wr_ready ignores rd_ready.
    logic [ASIZE:0]   wr_ptr;
    logic [ASIZE:0]   rd_ptr;
    logic [DSIZE-1:0] mem [DEPTH];
    logic             full;
    logic             empty;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ASIZE-1:0] == rd_ptr[ASIZE-1:0]) &&
                   (wr_ptr[ASIZE] != rd_ptr[ASIZE]);

    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign wr_en    = wr_valid && !full && clear_n;
    assign rd_en    = rd_ready && !empty && clear_n;

    assign rd_data      = mem[rd_ptr[ASIZE-1:0]];
    assign level        = wr_ptr - rd_ptr;
    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (!clear_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is deliberately left out of reset; stale entries are never visible
    // because rd_valid gates their meaning.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[ASIZE-1:0]] <= wr_data;
    end

`ifdef LEVEL_FIFO_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (!clear_n) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (wr_valid && full) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_level_fifo.sv
// Directed plus randomized bench for level_fifo (ASIZE=2, DSIZE=8, AF=3, AE=1),
// checked against a queue-based model of FIFO occupancy and order.
module tb_level_fifo;

    localparam int ASIZE = 2;
    localparam int DSIZE = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic             clk;
    logic             rst;
    logic             clear_n;
    logic [DSIZE-1:0] wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [DSIZE-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [ASIZE:0]   level;
    logic             almost_full;
    logic             almost_empty;
`ifdef LEVEL_FIFO_DROP_CNT_EN
    logic             overflow;
    logic [7:0]       drop_cnt;
`endif

    level_fifo #(
        .ASIZE(ASIZE), .DSIZE(DSIZE), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk), .rst(rst), .clear_n(clear_n),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
`ifdef LEVEL_FIFO_DROP_CNT_EN
        , .overflow(overflow), .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DSIZE-1:0] exp_q[$];
    int               m_ovf;
    int               m_drops;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf   = 0;
        m_drops = 0;
    endtask

    // Model of one clock edge, using inputs as they stand before the edge.
    task automatic model_edge();
        int n;
        n = exp_q.size();
        if (rst || !clear_n) begin
            model_reset();
        end else begin
            if (wr_valid && n == DEPTH) begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
            if (rd_ready && n > 0) void'(exp_q.pop_front());
            if (wr_valid && n < DEPTH) exp_q.push_back(wr_data);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = exp_q.size();
        check({tag, ".level"},    32'(level),        32'(n));
        check({tag, ".rd_valid"}, 32'(rd_valid),     32'(n > 0));
        check({tag, ".wr_ready"}, 32'(wr_ready),     32'(n < DEPTH));
        check({tag, ".afull"},    32'(almost_full),  32'(n >= AF));
        check({tag, ".aempty"},   32'(almost_empty), 32'(n <= AE));
        if (n > 0) check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_q[0]));
`ifdef LEVEL_FIFO_DROP_CNT_EN
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drops));
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic wv, input logic [DSIZE-1:0] wd, input logic rr);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
    endtask

    initial begin
        logic [DSIZE-1:0] wvals [4];
        wvals[0] = 8'h11; wvals[1] = 8'h22; wvals[2] = 8'h33; wvals[3] = 8'h44;

        rst = 1'b1; clear_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        model_reset();
        #2;
        check_all("reset_async");
        step("reset_hold");
        #2 rst = 1'b0;

        // Fill to full; almost_full at 3, wr_ready drops at 4, head stays 0x11
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, wvals[i], 1'b0);
            step($sformatf("fill%0d", i));
        end
        check("fill.head", 32'(rd_data), 32'h11);

        // Refused writes while full
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h55, 1'b0);
            step($sformatf("ovf%0d", i));
        end

        // Full: simultaneous read/write completes the read only
        drive(1'b1, 8'h66, 1'b1);
        step("full_rw");
        check("full_rw.level", 32'(level), 32'd3);

        // Down to level 2, then 10 cycles of simultaneous read/write
        drive(1'b0, 8'h00, 1'b1);
        step("to_lvl2");
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 1'b1);
            step($sformatf("rw%0d", i));
        end
        check("rw.level", 32'(level), 32'd2);

        // Level 3 then synchronous clear with a concurrent write
        drive(1'b1, 8'h77, 1'b0);
        step("to_lvl3");
        drive(1'b1, 8'h88, 1'b1);
        clear_n = 1'b0;
        step("clear");
        clear_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        step("after_clear");

        // Level 2, asynchronous reset between edges
        drive(1'b1, 8'hA1, 1'b0);
        step("pre_rst0");
        drive(1'b1, 8'hA2, 1'b0);
        step("pre_rst1");
        drive(1'b0, 8'h00, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("mid_rst");
        step("mid_rst_edge");
        #1 rst = 1'b0;

        // Randomized traffic, including occasional clears
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 99) < 45));
            clear_n = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            step($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests_run=%0d", tests_run);
        $fatal(1, "timeout");
    end

endmodule
